// File: rtl/column_buffer_writer_pkg.sv
// Shared definitions for the column buffer writer slice.
// Contents: default geometry (NUM_COLUMNS, IDX_W), the "no wall" distance
// value FAR_DISTANCE, and the writer FSM state type.
// Optional feature macro: COLUMN_BUF_CLEAR_EN adds the CLEAR state.
package gpu_pkg;

    localparam int unsigned NUM_COLUMNS  = 320;
    localparam int unsigned IDX_W        = 9;
    localparam logic [15:0] FAR_DISTANCE = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_VSYNC = 2'd1,
        S_SWAP       = 2'd2
`ifdef COLUMN_BUF_CLEAR_EN
        ,
        S_CLEAR      = 2'd3
`endif
    } state_t;

endpackage

// File: rtl/column_buffer_writer_if.sv
// CPU write / GPU read bus of the column buffer writer.
// master: CPU + GPU side (drives writes, commit, v_sync, reading_index).
// slave : column_buffer_writer (returns busy, distance, texture, frame_count).
interface column_buffer_writer_if #(
    parameter int unsigned IDX_W = gpu_pkg::IDX_W
);

    logic             cpu_wr_en;
    logic             cpu_wr_sel;
    logic [IDX_W-1:0] cpu_wr_addr;
    logic [15:0]      cpu_wr_data;
    logic             cpu_commit;
    logic             cpu_busy;
    logic             v_sync;
    logic [IDX_W-1:0] reading_index;
    logic [15:0]      distance;
    logic [15:0]      texture;
    logic [7:0]       frame_count;

    modport master (
        output cpu_wr_en, cpu_wr_sel, cpu_wr_addr, cpu_wr_data, cpu_commit,
        output v_sync, reading_index,
        input  cpu_busy, distance, texture, frame_count
    );

    modport slave (
        input  cpu_wr_en, cpu_wr_sel, cpu_wr_addr, cpu_wr_data, cpu_commit,
        input  v_sync, reading_index,
        output cpu_busy, distance, texture, frame_count
    );

endinterface

// File: rtl/column_buffer_writer_bank.sv
// column_bank: NUM_COLUMNS x 32-bit storage, word = {distance, texture}.
// Ports: clk; we/wmask/waddr/wdata single write port (wmask[1] = distance
// half, wmask[0] = texture half); raddr/rdata registered read port.
// Contents are never reset. waddr must be < NUM_COLUMNS; an out-of-range
// raddr returns an undefined word that the caller masks.
module column_bank #(
    parameter int unsigned NUM_COLUMNS = 320,
    parameter int unsigned IDX_W       = 9
) (
    input  logic             clk,
    input  logic             we,
    input  logic [1:0]       wmask,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [31:0] mem [NUM_COLUMNS];

    always_ff @(posedge clk) begin
        if (we) begin
            if (wmask[1]) mem[waddr][31:16] <= wdata[31:16];
            if (wmask[0]) mem[waddr][15:0]  <= wdata[15:0];
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/column_buffer_writer.sv
// column_buffer_writer: double-buffered per-column {distance, texture} store.
// The CPU fills the back bank and requests a swap with cpu_commit; the swap
// happens on the next v_sync falling edge. The GPU reads the front bank
// with one cycle of latency.
// Ports: clk, clr (synchronous active-high reset), bus (slave modport of
// column_buffer_writer_if: CPU write/commit/busy, v_sync, GPU read, frame_count).
// Optional macro COLUMN_BUF_CLEAR_EN: after each swap (and after reset) the
// new back bank is filled with FAR_DISTANCE / 0, one entry per cycle.
module column_buffer_writer #(
    parameter int unsigned NUM_COLUMNS = gpu_pkg::NUM_COLUMNS,
    parameter int unsigned IDX_W       = gpu_pkg::IDX_W
) (
    input  logic                    clk,
    input  logic                    clr,
    column_buffer_writer_if.slave   bus
);

    import gpu_pkg::*;

    localparam logic [IDX_W:0] NCOL = (IDX_W+1)'(NUM_COLUMNS);

    state_t     state;
    logic       front_sel;
    logic       busy_q;
    logic       vs_q;
    logic [7:0] fc_q;

`ifdef COLUMN_BUF_CLEAR_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COLUMNS - 1);
    logic [IDX_W-1:0] clr_idx;
`endif

    // Shared write port signals, steered to the back bank (!front_sel).
    logic             we;
    logic [1:0]       wmask;
    logic [IDX_W-1:0] waddr;
    logic [31:0]      wdata;
    logic             we0;
    logic             we1;
    logic [31:0]      rdata0;
    logic [31:0]      rdata1;

    // Read-side qualifiers registered alongside the banks' read registers.
    logic rd_zero;
    logic rd_bank;
    logic rd_oor;

    logic wr_in_range;
    assign wr_in_range = {1'b0, bus.cpu_wr_addr} < NCOL;

    always_comb begin
        we    = 1'b0;
        wmask = 2'b00;
        waddr = bus.cpu_wr_addr;
        wdata = {bus.cpu_wr_data, bus.cpu_wr_data};
        if (!clr && state == S_IDLE && bus.cpu_wr_en && wr_in_range) begin
            we    = 1'b1;
            wmask = bus.cpu_wr_sel ? 2'b01 : 2'b10;
        end
`ifdef COLUMN_BUF_CLEAR_EN
        if (!clr && state == S_CLEAR) begin
            we    = 1'b1;
            wmask = 2'b11;
            waddr = clr_idx;
            wdata = {FAR_DISTANCE, 16'h0000};
        end
`endif
    end

    assign we0 = we &  front_sel;
    assign we1 = we & ~front_sel;

    column_bank #(.NUM_COLUMNS(NUM_COLUMNS), .IDX_W(IDX_W)) u_bank0 (
        .clk   (clk),
        .we    (we0),
        .wmask (wmask),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (bus.reading_index),
        .rdata (rdata0)
    );

    column_bank #(.NUM_COLUMNS(NUM_COLUMNS), .IDX_W(IDX_W)) u_bank1 (
        .clk   (clk),
        .we    (we1),
        .wmask (wmask),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (bus.reading_index),
        .rdata (rdata1)
    );

    // front_sel is sampled with the index, so a read issued in the SWAP
    // cycle still comes from the old front bank.
    always_ff @(posedge clk) begin
        if (clr) begin
            rd_zero <= 1'b1;
            rd_bank <= 1'b0;
            rd_oor  <= 1'b0;
        end else begin
            rd_zero <= 1'b0;
            rd_bank <= front_sel;
            rd_oor  <= !({1'b0, bus.reading_index} < NCOL);
        end
    end

    always_comb begin
        if (rd_zero) begin
            bus.distance = '0;
            bus.texture  = '0;
        end else if (rd_oor) begin
            bus.distance = FAR_DISTANCE;
            bus.texture  = '0;
        end else if (rd_bank) begin
            bus.distance = rdata1[31:16];
            bus.texture  = rdata1[15:0];
        end else begin
            bus.distance = rdata0[31:16];
            bus.texture  = rdata0[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            front_sel <= 1'b0;
            fc_q      <= '0;
            vs_q      <= 1'b1;
`ifdef COLUMN_BUF_CLEAR_EN
            state     <= S_CLEAR;
            busy_q    <= 1'b1;
            clr_idx   <= '0;
`else
            state     <= S_IDLE;
            busy_q    <= 1'b0;
`endif
        end else begin
            vs_q <= bus.v_sync;
            case (state)
                S_IDLE: begin
                    if (bus.cpu_commit) begin
                        state  <= S_WAIT_VSYNC;
                        busy_q <= 1'b1;
                    end
                end
                S_WAIT_VSYNC: begin
                    if (vs_q && !bus.v_sync) state <= S_SWAP;
                end
                S_SWAP: begin
                    front_sel <= ~front_sel;
                    fc_q      <= fc_q + 8'd1;
`ifdef COLUMN_BUF_CLEAR_EN
                    state     <= S_CLEAR;
                    clr_idx   <= '0;
`else
                    state     <= S_IDLE;
                    busy_q    <= 1'b0;
`endif
                end
`ifdef COLUMN_BUF_CLEAR_EN
                S_CLEAR: begin
                    if (clr_idx == LAST_IDX) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                    clr_idx <= clr_idx + 1'b1;
                end
`endif
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cpu_busy    = busy_q;
    assign bus.frame_count = fc_q;

endmodule

// File: tb/tb_column_buffer_writer.sv
// Self-checking bench for column_buffer_writer: a transaction-level model
// of both banks is compared against the DUT outputs every cycle, with
// directed scenarios pinned by literal expectations and a random phase.
// Honours COLUMN_BUF_CLEAR_EN when the design is built with it.
module tb_column_buffer_writer;

    localparam int N = 320;
    localparam int W = 9;

    logic clk = 1'b0;
    logic clr;

    always #5 clk = ~clk;

    column_buffer_writer_if #(.IDX_W(W)) bus ();

    column_buffer_writer #(.NUM_COLUMNS(N), .IDX_W(W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] m_dist [2][N];
    logic [15:0] m_tex  [2][N];
    bit          k_dist [2][N];
    bit          k_tex  [2][N];
    int          m_front;
    int          m_fc;
    bit          m_pending;
    bit          m_swap_next;
    int          m_clear_left;
    bit          m_prev_vs;
    bit          m_busy;
    logic [15:0] e_dist;
    logic [15:0] e_tex;
    bit          e_dk;
    bit          e_tk;
    bit          model_live = 1'b0;

    always @(posedge clk) begin : model
        int  idx;
        int  back;
        int  addr;
        bit  busy_before;
        idx = int'(bus.reading_index);
        if (clr) begin
            e_dist = '0; e_tex = '0; e_dk = 1'b1; e_tk = 1'b1;
            m_front = 0; m_fc = 0; m_pending = 1'b0; m_swap_next = 1'b0;
            m_prev_vs = 1'b1;
`ifdef COLUMN_BUF_CLEAR_EN
            m_clear_left = N;
`else
            m_clear_left = 0;
`endif
            m_busy = (m_clear_left > 0);
            model_live = 1'b1;
        end else begin
            if (idx >= N) begin
                e_dist = 16'hFFFF; e_tex = 16'h0000; e_dk = 1'b1; e_tk = 1'b1;
            end else begin
                e_dist = m_dist[m_front][idx]; e_dk = k_dist[m_front][idx];
                e_tex  = m_tex[m_front][idx];  e_tk = k_tex[m_front][idx];
            end
            busy_before = m_busy;
            back = 1 - m_front;
            if (m_swap_next) begin
                m_swap_next = 1'b0;
                m_front = 1 - m_front;
                m_fc = (m_fc + 1) % 256;
`ifdef COLUMN_BUF_CLEAR_EN
                m_clear_left = N;
`endif
            end else if (m_clear_left > 0) begin
                m_dist[1 - m_front][N - m_clear_left] = 16'hFFFF;
                m_tex[1 - m_front][N - m_clear_left]  = 16'h0000;
                k_dist[1 - m_front][N - m_clear_left] = 1'b1;
                k_tex[1 - m_front][N - m_clear_left]  = 1'b1;
                m_clear_left--;
            end
            if (m_pending && m_prev_vs && !bus.v_sync) begin
                m_pending = 1'b0;
                m_swap_next = 1'b1;
            end
            if (!busy_before) begin
                addr = int'(bus.cpu_wr_addr);
                if (bus.cpu_wr_en && addr < N) begin
                    if (bus.cpu_wr_sel) begin
                        m_tex[back][addr] = bus.cpu_wr_data; k_tex[back][addr] = 1'b1;
                    end else begin
                        m_dist[back][addr] = bus.cpu_wr_data; k_dist[back][addr] = 1'b1;
                    end
                end
                if (bus.cpu_commit) m_pending = 1'b1;
            end
            m_prev_vs = bus.v_sync;
            m_busy = m_pending || m_swap_next || (m_clear_left > 0);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        if (model_live) begin
            check("cpu_busy", 32'(bus.cpu_busy), 32'(m_busy));
            check("frame_count", 32'(bus.frame_count), 32'(m_fc[7:0]));
            if (e_dk) check("distance", 32'(bus.distance), 32'(e_dist));
            if (e_tk) check("texture", 32'(bus.texture), 32'(e_tex));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(input bit sel, input int addr, input logic [15:0] data);
        bus.cpu_wr_en   = 1'b1;
        bus.cpu_wr_sel  = sel;
        bus.cpu_wr_addr = W'(addr);
        bus.cpu_wr_data = data;
        step();
        bus.cpu_wr_en   = 1'b0;
    endtask

    task automatic commit();
        bus.cpu_commit = 1'b1;
        step();
        bus.cpu_commit = 1'b0;
    endtask

    task automatic vsync_fall();
        bus.v_sync = 1'b0;
        step();
        bus.v_sync = 1'b1;
        step();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (bus.cpu_busy && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (bus.cpu_busy) begin
            errors++;
            $display("FAIL wait_idle: cpu_busy=1 after %0d cycles, required 0", budget);
        end
    endtask

    task automatic do_swap();
        commit();
        vsync_fall();
        wait_idle(N + 50);
    endtask

    task automatic read_at(input int idx);
        bus.reading_index = W'(idx);
        step();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int n;
        clr               = 1'b1;
        bus.cpu_wr_en     = 1'b0;
        bus.cpu_wr_sel    = 1'b0;
        bus.cpu_wr_addr   = '0;
        bus.cpu_wr_data   = '0;
        bus.cpu_commit    = 1'b0;
        bus.v_sync        = 1'b1;
        bus.reading_index = '0;
        step();
        step();
        check("reset_distance", 32'(bus.distance), 32'h0);
        check("reset_texture", 32'(bus.texture), 32'h0);
        check("reset_frame_count", 32'(bus.frame_count), 32'h0);
        clr = 1'b0;
        wait_idle(N + 50);

        // Give both banks known contents.
        for (int pass = 0; pass < 2; pass++) begin
            for (int c = 0; c < N; c++) begin
                wr(1'b0, c, 16'($urandom));
                wr(1'b1, c, 16'($urandom));
            end
            do_swap();
        end

        // Basic write / commit / v_sync swap.
        clr = 1'b1; step(); clr = 1'b0;
        wait_idle(N + 50);
        wr(1'b0, 5, 16'h0123);
        do_swap();
        read_at(5);
        check("basic_frame_count", 32'(bus.frame_count), 32'd1);
        check("basic_distance", 32'(bus.distance), 32'h0123);

        // Out-of-range writes are dropped, out-of-range reads give far/0.
        wr(1'b0, 320, 16'h1111);
        wr(1'b1, 511, 16'h2222);
        do_swap();
        read_at(320);
        check("oor320_distance", 32'(bus.distance), 32'hFFFF);
        check("oor320_texture", 32'(bus.texture), 32'h0000);
        read_at(511);
        check("oor511_distance", 32'(bus.distance), 32'hFFFF);

        // Writes while busy are ignored.
        wr(1'b0, 7, 16'h7777);
        commit();
        wr(1'b0, 7, 16'hAAAA);
        vsync_fall();
        wait_idle(N + 50);
        read_at(7);
        check("busy_write_ignored", 32'(bus.distance), 32'h7777);

        // Write and commit in the same cycle.
        bus.cpu_wr_en = 1'b1; bus.cpu_wr_sel = 1'b0;
        bus.cpu_wr_addr = W'(9); bus.cpu_wr_data = 16'hBEEF;
        bus.cpu_commit = 1'b1;
        step();
        bus.cpu_wr_en = 1'b0; bus.cpu_commit = 1'b0;
        vsync_fall();
        wait_idle(N + 50);
        read_at(9);
        check("write_with_commit", 32'(bus.distance), 32'hBEEF);

        // Busy length from the SWAP cycle onward.
        commit();
        bus.v_sync = 1'b0;
        step();
        bus.v_sync = 1'b1;
        n = 0;
        while (bus.cpu_busy && n < 1000) begin
            n++;
            step();
        end
`ifdef COLUMN_BUF_CLEAR_EN
        check("busy_cycles_after_vsync", 32'(n), 32'(N + 1));
`else
        check("busy_cycles_after_vsync", 32'(n), 32'd1);
`endif
        do_swap();
        for (int c = 0; c < N + 2; c++) read_at(c);
        read_at(N - 1);
        read_at(0);

        // Reset during WAIT_VSYNC aborts the swap.
        commit();
        step();
        clr = 1'b1; step(); clr = 1'b0;
        check("abort_frame_count", 32'(bus.frame_count), 32'd0);
        wait_idle(N + 50);
        vsync_fall();
        step();
        step();
        check("abort_no_swap_fc", 32'(bus.frame_count), 32'd0);
        check("abort_not_busy", 32'(bus.cpu_busy), 32'd0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            bus.cpu_wr_en   = 1'($urandom_range(0, 1));
            bus.cpu_wr_sel  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0)
                bus.cpu_wr_addr = W'($urandom_range(N, 511));
            else
                bus.cpu_wr_addr = W'($urandom_range(0, N - 1));
            bus.cpu_wr_data = 16'($urandom);
            bus.cpu_commit  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) bus.v_sync = ~bus.v_sync;
            bus.reading_index = W'($urandom_range(0, N + 20));
            clr = ($urandom_range(0, 999) == 0);
            step();
        end
        clr = 1'b0;
        bus.cpu_wr_en = 1'b0;
        bus.cpu_commit = 1'b0;
        bus.v_sync = 1'b1;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/column_buffer_writer.md
COLUMN_BUFFER_WRITER -- requirements
Module: column_buffer_writer

Interface
REQ-001 Parameter NUM_COLUMNS, default 320: number of screen columns held per bank.
REQ-002 Parameter IDX_W, default 9: column index width.
REQ-003 clk  in  1  single system clock; all logic on posedge clk.
REQ-004 clr  in  1  synchronous, active-high reset.
REQ-005 cpu_wr_en  in  1  write strobe; one write per asserted cycle.
REQ-006 cpu_wr_sel  in  1  write target: 0 = distance word, 1 = texture word.
REQ-007 cpu_wr_addr  in  IDX_W  column index of the write.
REQ-008 cpu_wr_data  in  16  write data.
REQ-009 cpu_commit  in  1  single-cycle pulse requesting a back/front bank swap.
REQ-010 cpu_busy  out  1  high while a commit is pending, swapping or clearing.
REQ-011 v_sync  in  1  active-low vertical sync from the VGA controller.
REQ-012 reading_index  in  IDX_W  column requested by the GPU.
REQ-013 distance  out  16  front-bank distance for reading_index.
REQ-014 texture  out  16  front-bank texture word for reading_index.
REQ-015 frame_count  out  8  number of completed swaps, modulo 256.

Function
REQ-016 The block SHALL hold two banks of NUM_COLUMNS x {distance, texture}; the GPU reads only the front bank and the CPU writes only the back bank.
REQ-017 Read path SHALL be registered: distance/texture SHALL reflect reading_index sampled one cycle earlier.
REQ-018 reading_index >= NUM_COLUMNS SHALL return distance 16'hFFFF and texture 16'h0000.
REQ-019 The FSM SHALL have states IDLE, WAIT_VSYNC, SWAP and CLEAR; CLEAR exists only with the macro in REQ-031.
REQ-020 In IDLE, a cycle with cpu_wr_en high and cpu_wr_addr < NUM_COLUMNS SHALL write cpu_wr_data into the selected field of the back bank; writes with out-of-range addresses SHALL be dropped.
REQ-021 In IDLE, cpu_commit SHALL move the FSM to WAIT_VSYNC on the next cycle and raise cpu_busy in that same next cycle.
REQ-022 When cpu_wr_en and cpu_commit are both high in IDLE, the write SHALL land in the back bank before the swap.
REQ-023 Writes and commits received while cpu_busy is high SHALL be ignored, with no queuing.
REQ-024 The FSM SHALL leave WAIT_VSYNC on a v_sync falling edge, detected by comparing v_sync against its registered value from the previous cycle, and enter SWAP.
REQ-025 SWAP SHALL last one cycle: toggle front_sel and increment frame_count (255 wraps to 0), then go to IDLE.
REQ-026 A reading_index sampled in the SWAP cycle SHALL still read the old front bank; the first read from the new bank is the index sampled one cycle after SWAP.
REQ-027 cpu_busy SHALL be high exactly in WAIT_VSYNC, SWAP and CLEAR.

Reset
REQ-028 On clr, the block SHALL set state to IDLE, front_sel to 0, frame_count to 0, cpu_busy to 0, distance to 0, texture to 0 and the v_sync edge register to 1.
REQ-029 Bank contents SHALL NOT be reset, except as given in REQ-031.
REQ-030 clr asserted mid-WAIT_VSYNC or mid-CLEAR SHALL abort that operation; no swap occurs.

Configuration
REQ-031 With COLUMN_BUF_CLEAR_EN defined:
- SWAP SHALL go to CLEAR instead of IDLE.
- CLEAR SHALL write distance 16'hFFFF and texture 0 into every entry of the new back bank, one entry per cycle, indices 0..NUM_COLUMNS-1, then return to IDLE. This takes NUM_COLUMNS cycles.
- Reset SHALL enter CLEAR on bank 1 instead of IDLE.
REQ-032 With COLUMN_BUF_CLEAR_EN undefined, the CLEAR state and its counter SHALL NOT exist, and SWAP SHALL go directly to IDLE.

Structure
REQ-033 Shared package gpu_pkg SHALL hold NUM_COLUMNS, IDX_W, FAR_DISTANCE (16'hFFFF) and the FSM state typedef.
REQ-034 A sub-module column_bank (NUM_COLUMNS x 32-bit, one write port, one registered read port) SHALL be instantiated twice.

Verification
REQ-035 Write distance 0x0123 to column 5, commit, then give a v_sync falling edge -> frame_count = 1; reading_index = 5 returns distance 0x0123 one cycle later.
REQ-036 Write to column 320 and column 511, then swap -> no bank changes; reading_index = 320 returns 0xFFFF/0x0000.
REQ-037 Commit, then write column 7 while cpu_busy is high -> after the swap, column 7 in the new front bank is unchanged.
REQ-038 Assert cpu_wr_en and cpu_commit in the same cycle (column 9, 0xBEEF), then swap -> column 9 reads 0xBEEF.
REQ-039 With COLUMN_BUF_CLEAR_EN, swap -> cpu_busy stays high for exactly 321 cycles (SWAP + 320 CLEAR), and every back-bank entry reads 0xFFFF/0 after the next swap.
REQ-040 Assert clr during WAIT_VSYNC -> front_sel = 0, frame_count = 0, and no swap occurs on the following v_sync falling edge.
